// File: rtl/amiga_clk_enable_gen_pkg.sv
// Shared types and constants for the Amiga clock-enable generator.
// Holds the lock FSM encoding, phase decode points and E-clock defaults.
package amiga_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [2:0] PH_CLK7  = 3'd3;
    localparam logic [2:0] PH_CLK7N = 3'd1;
    localparam logic [2:0] PH_CCK   = 3'd7;

    localparam int ECLK_DIV_DEF  = 10;
    localparam int ECLK_HIGH_DEF = 4;

    // Low two phase bits select the 7 MHz position inside a CCK period.
    function automatic logic [1:0] phase_lo(input logic [2:0] ph);
        return ph[1:0];
    endfunction

endpackage

// File: rtl/amiga_clk_enable_gen_if.sv
// PLL-lock input and timing-strobe bundle for the clock-enable generator.
// master = generator side, slave = PLL/consumer side.
interface amiga_clk_enable_gen_if;

    logic       pll_locked;
    logic       run_rst;
    logic [2:0] phase;
    logic       clk7_en;
    logic       clk7n_en;
    logic       cck;
    logic       cck_en;
    logic       eclk;
    logic       e_en;

    modport master (
        input  pll_locked,
        output run_rst, phase, clk7_en, clk7n_en, cck, cck_en, eclk, e_en
    );

    modport slave (
        output pll_locked,
        input  run_rst, phase, clk7_en, clk7n_en, cck, cck_en, eclk, e_en
    );

endinterface

// File: rtl/amiga_clk_enable_gen_sync.sv
// Single-bit CDC synchroniser: STAGES-deep flop chain with synchronous clear.
module amiga_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the chain; clr empties it.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/amiga_clk_enable_gen.sv
// Lock-qualified core reset and Amiga timing enables (7 MHz, CCK, E-clock)
// derived from a single 28 MHz clock; all outputs decode registered state only.
module amiga_clk_enable_gen
    import amiga_clk_pkg::*;
#(
    parameter int LOCK_HOLD   = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int ECLK_DIV    = ECLK_DIV_DEF,
    parameter int ECLK_HIGH   = ECLK_HIGH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    amiga_clk_enable_gen_if.master  bus
);

    localparam int HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam int EW = (ECLK_DIV > 1) ? $clog2(ECLK_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LOCK_HOLD - 1);
    localparam logic [EW-1:0] ECNT_LAST  = EW'(ECLK_DIV - 1);
    localparam logic [EW-1:0] ECNT_HIGH  = EW'(ECLK_DIV - ECLK_HIGH);

    logic          locked_s;
    state_t        state_r, state_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [2:0]    phase_r, phase_s;
    logic [EW-1:0] ecnt_r, ecnt_s;
    logic          run_s;
    logic          clk7_s;

    amiga_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .clr (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // State, hold counter, phase and E counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_LOCK;
            hold_r  <= '0;
            phase_r <= 3'd0;
            ecnt_r  <= '0;
        end else begin
            state_r <= state_s;
            hold_r  <= hold_s;
            phase_r <= phase_s;
            ecnt_r  <= ecnt_s;
        end
    end

    // Lock FSM: any deassertion of the synchronised lock restarts qualification.
    always_comb begin
        state_s = state_r;
        hold_s  = '0;
        case (state_r)
            WAIT_LOCK: begin
                if (locked_s) state_s = HOLD;
                else          state_s = WAIT_LOCK;
            end
            HOLD: begin
                if (!locked_s) begin
                    state_s = WAIT_LOCK;
                end else if (hold_r == HOLD_LAST) begin
                    state_s = RUN;
                end else begin
                    hold_s = hold_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (!locked_s) state_s = WAIT_LOCK;
                else           state_s = RUN;
            end
            default: state_s = WAIT_LOCK;
        endcase
    end

    assign run_s  = (state_r == RUN);
    assign clk7_s = run_s && (phase_lo(phase_r) == phase_lo(PH_CLK7));

    // Phase and E counters only move in RUN so relock alignment is fixed.
    always_comb begin
        phase_s = 3'd0;
        ecnt_s  = '0;
        if (run_s) begin
            phase_s = phase_r + 3'd1;
            if (clk7_s) begin
                if (ecnt_r == ECNT_LAST) ecnt_s = '0;
                else                     ecnt_s = ecnt_r + {{(EW-1){1'b0}}, 1'b1};
            end else begin
                ecnt_s = ecnt_r;
            end
        end else begin
            phase_s = 3'd0;
            ecnt_s  = '0;
        end
    end

    assign bus.run_rst  = !run_s;
    assign bus.phase    = run_s ? phase_r : 3'd0;
    assign bus.clk7_en  = clk7_s;
    assign bus.clk7n_en = run_s && (phase_lo(phase_r) == phase_lo(PH_CLK7N));
    assign bus.cck      = run_s && phase_r[2];
    assign bus.cck_en   = run_s && (phase_r == PH_CCK);
    assign bus.eclk     = run_s && (ecnt_r >= ECNT_HIGH);
    assign bus.e_en     = clk7_s && (ecnt_r == ECNT_LAST);

endmodule

// File: tb/tb_amiga_clk_enable_gen.sv
// Scoreboard bench: a timeline model of lock qualification and strobe timing
// pushes expected outputs per edge; they are popped and compared after the edge.
module tb_amiga_clk_enable_gen;

    localparam int LH  = 16;
    localparam int SS  = 2;
    localparam int REL = LH + 1;

    typedef struct {
        logic       run_rst;
        logic [2:0] phase;
        logic       clk7_en;
        logic       clk7n_en;
        logic       cck;
        logic       cck_en;
        logic       eclk;
        logic       e_en;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];

    int n_cmp;
    int n_bad;

    // Model: streak of high lock samples, delayed through the synchroniser depth.
    int h, d1, d2, rcnt;
    bit run_m;

    bit counting;
    int cnt_clk7, cnt_clk7n, cnt_cck_en, cnt_e_en;

    amiga_clk_enable_gen_if bus ();

    amiga_clk_enable_gen #(
        .LOCK_HOLD   (LH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        if (obs !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step(input logic rst_v, input logic lk_v);
        exp_t e;
        int   c;
        @(negedge clk);
        rst            = rst_v;
        bus.pll_locked = lk_v;
        if (rst_v) begin
            h = 0; d1 = 0; d2 = 0; run_m = 1'b0;
        end else begin
            d2 = d1;
            d1 = h;
            h  = lk_v ? h + 1 : 0;
            if (d2 >= REL) begin
                rcnt  = run_m ? rcnt + 1 : 0;
                run_m = 1'b1;
            end else begin
                run_m = 1'b0;
            end
        end
        c = rcnt;
        e.run_rst  = !run_m;
        e.phase    = run_m ? 3'(c % 8) : 3'd0;
        e.clk7_en  = run_m && (c % 4 == 3);
        e.clk7n_en = run_m && (c % 4 == 1);
        e.cck      = run_m && (c % 8 >= 4);
        e.cck_en   = run_m && (c % 8 == 7);
        e.eclk     = run_m && (c % 40 >= 24);
        e.e_en     = run_m && (c % 40 == 39);
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val("run_rst",  32'(bus.run_rst),  32'(e.run_rst));
            check_val("phase",    32'(bus.phase),    32'(e.phase));
            check_val("clk7_en",  32'(bus.clk7_en),  32'(e.clk7_en));
            check_val("clk7n_en", 32'(bus.clk7n_en), 32'(e.clk7n_en));
            check_val("cck",      32'(bus.cck),      32'(e.cck));
            check_val("cck_en",   32'(bus.cck_en),   32'(e.cck_en));
            check_val("eclk",     32'(bus.eclk),     32'(e.eclk));
            check_val("e_en",     32'(bus.e_en),     32'(e.e_en));
            check_val("clk7_excl", 32'(bus.clk7_en && bus.clk7n_en), 32'd0);
        end
        if (counting) begin
            cnt_clk7   += int'(bus.clk7_en);
            cnt_clk7n  += int'(bus.clk7n_en);
            cnt_cck_en += int'(bus.cck_en);
            cnt_e_en   += int'(bus.e_en);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        h = 0; d1 = 0; d2 = 0; rcnt = 0; run_m = 1'b0;
        counting = 1'b0;
        cnt_clk7 = 0; cnt_clk7n = 0; cnt_cck_en = 0; cnt_e_en = 0;
        rst = 1'b1;
        bus.pll_locked = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // Lock held from the first released edge: release on the 19th edge.
        for (int i = 0; i < SS + LH; i++) step(1'b0, 1'b1);
        check_val("rel_edge18", 32'(bus.run_rst), 32'd1);
        counting = 1'b1;
        step(1'b0, 1'b1);
        check_val("rel_edge19", 32'(bus.run_rst), 32'd0);
        for (int i = 1; i < 64; i++) step(1'b0, 1'b1);
        check_val("clk7_cnt64",  32'(cnt_clk7),   32'd16);
        check_val("clk7n_cnt64", 32'(cnt_clk7n),  32'd16);
        check_val("cck_en_cnt64", 32'(cnt_cck_en), 32'd8);
        for (int i = 64; i < 120; i++) step(1'b0, 1'b1);
        check_val("e_en_cnt120", 32'(cnt_e_en), 32'd3);
        counting = 1'b0;

        // Drop lock once phase 5 is showing.
        for (int i = 0; i < 16 && !(run_m && (rcnt % 8 == 5)); i++) step(1'b0, 1'b1);
        check_val("drop_phase", 32'(bus.phase), 32'd5);
        for (int i = 0; i < SS + 1; i++) step(1'b0, 1'b0);
        check_val("loss_run_rst", 32'(bus.run_rst), 32'd1);
        check_val("loss_enables", 32'({bus.clk7_en, bus.clk7n_en, bus.cck_en, bus.e_en, bus.cck, bus.eclk}), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Glitchy relock: 10 high, 3 low, then release 19 edges after the second rise.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < SS + LH; i++) step(1'b0, 1'b1);
        check_val("relock_edge18", 32'(bus.run_rst), 32'd1);
        step(1'b0, 1'b1);
        check_val("relock_edge19", 32'(bus.run_rst), 32'd0);
        check_val("relock_phase0", 32'(bus.phase), 32'd0);
        for (int i = 0; i < 21; i++) step(1'b0, 1'b1);

        // One-cycle reset mid-RUN with lock held high.
        step(1'b1, 1'b1);
        check_val("srst_run_rst", 32'(bus.run_rst), 32'd1);
        check_val("srst_phase", 32'(bus.phase), 32'd0);
        for (int i = 0; i < SS + LH; i++) step(1'b0, 1'b1);
        check_val("srst_edge18", 32'(bus.run_rst), 32'd1);
        step(1'b0, 1'b1);
        check_val("srst_edge19", 32'(bus.run_rst), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/amiga_clk_enable_gen.md
Name: amiga_clk_enable_gen

Overview:
- Runs directly downstream of the core PLL.
- Clocked from the 28.375160 MHz PLL output; consumes the PLL `locked` flag.
- Produces the core run reset plus all Amiga timing strobes as single-cycle clock enables: 7 MHz, 7 MHz inverted, CCK (3.546895 MHz) and E-clock (709 kHz).
- Downstream logic (chipset, CPU bridge, CIAs) runs on the same 28 MHz clock and is gated by these enables only, never by derived clocks.

Parameters:
- LOCK_HOLD, 1024: cycles `pll_locked` must stay stable high before `run_rst` is released.
- SYNC_STAGES, 2: flop depth of the `pll_locked` synchroniser; minimum 2.
- ECLK_DIV, 10: 7 MHz ticks per E-clock period.
- ECLK_HIGH, 4: 7 MHz ticks E-clock is high per period; must be less than ECLK_DIV.

Ports:
- clk  in  1  28.375160 MHz core clock from the PLL.
- rst  in  1  One clock; reset is synchronous and active-high.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- run_rst  out  1  Core reset; 1 until the lock has been held long enough.
- phase  out  3  Position within the 8-cycle CCK period.
- clk7_en  out  1  7 MHz rising enable.
- clk7n_en  out  1  7 MHz falling enable.
- cck  out  1  CCK level.
- cck_en  out  1  CCK rising enable.
- eclk  out  1  E-clock level.
- e_en  out  1  One pulse per E period (CIA tick).

Behaviour:
- Reset (`rst`=1 at an edge) clears:
  - synchroniser flops
  - state to WAIT_LOCK
  - hold counter, phase and E counter to 0
- Reset output values: `run_rst`=1; `phase`, `clk7_en`, `clk7n_en`, `cck`, `cck_en`, `eclk`, `e_en` all 0.
- Reset mid-operation aborts immediately: at the next edge, outputs equal their reset values.
- `locked_s` is the last stage of the SYNC_STAGES-flop chain sampling `pll_locked`.
- State machine, registered state:
  - WAIT_LOCK: `locked_s`=1 goes to HOLD with hold counter=0.
  - HOLD: hold counter increments each cycle. `locked_s`=0 returns to WAIT_LOCK, counter cleared. Counter==LOCK_HOLD-1 with `locked_s`=1 goes to RUN.
  - RUN: `locked_s`=0 goes to WAIT_LOCK at the next edge.
- `run_rst` = (state != RUN), decoded from the state register. No combinational path from any input to any output.
- Release latency: with `pll_locked` rising before edge 0 and held, RUN and `run_rst`=0 appear after edge SYNC_STAGES+LOCK_HOLD+1.
- Phase counter:
  - Held at 0 when not in RUN.
  - In RUN, increments by 1 each cycle mod 8 (3 bits, wraps 7 to 0).
  - First RUN cycle shows `phase`=0.
- Enable decodes (all forced 0 outside RUN):
  - `clk7_en` = `phase[1:0]`==3
  - `clk7n_en` = `phase[1:0]`==1
  - `cck_en` = `phase`==7
  - `cck` = `phase[2]`
- Enable spacing: `clk7_en` fires every 4 cycles and `cck_en` every 8. `clk7_en` and `clk7n_en` are never high in the same cycle.
- E counter:
  - Range 0..ECLK_DIV-1; advances only on cycles with `clk7_en`=1; wraps ECLK_DIV-1 to 0.
  - Held at 0 outside RUN.
  - `eclk` = (ecnt >= ECLK_DIV-ECLK_HIGH).
  - `e_en` = `clk7_en` AND ecnt==ECLK_DIV-1.
  - Defaults give a 40-cycle E period: high 16 cycles, low 24.
- Lock loss in RUN:
  - `run_rst` rises and all enables drop within SYNC_STAGES+1 edges.
  - Counters restart from 0 on re-entry to RUN, so phase alignment after relock is deterministic.
- `pll_locked` glitch shorter than one clk period: may be missed by the synchroniser. If captured, it is treated as a real lock loss.

Decomposition:
- Package `amiga_clk_pkg`:
  - state enum (WAIT_LOCK, HOLD, RUN)
  - phase decode constants (PH_CLK7=3, PH_CLK7N=1, PH_CCK=7)
  - default ECLK_DIV and ECLK_HIGH
- One natural sub-module, `amiga_bit_sync`: a parameterised SYNC_STAGES flop chain with synchronous clear. It is reused elsewhere for CDC of single bits.

Test Plan:
- LOCK_HOLD=16: assert `rst` 3 cycles, then hold `pll_locked`=1 -> `run_rst` stays 1 through edge 18 and is 0 after edge 19; all enables 0 before that.
- LOCK_HOLD=16: `pll_locked` high 10 cycles, low 3, high again -> hold count restarts; release occurs 19 edges after the second rise.
- RUN for 64 cycles ->
  - `clk7_en` at `phase` 3 and 7 (16 pulses)
  - `clk7n_en` at `phase` 1 and 5 (16 pulses)
  - `cck_en` 8 pulses, at `phase` 7 only
  - `cck` high for `phase` 4..7
- RUN for 120 cycles with default ECLK -> `eclk` period 40 cycles, high 16 consecutive cycles; `e_en` exactly 3 pulses, each coincident with `clk7_en` on the last high cycle.
- Drop `pll_locked` in RUN at `phase`=5 -> `run_rst`=1 and every enable 0 within 3 edges; relock -> `phase` restarts at 0.
- Assert `rst` mid-RUN for 1 cycle with `pll_locked` held high -> next edge `run_rst`=1, `phase`=0; re-release after SYNC_STAGES+LOCK_HOLD+1 edges.
